multicycle_control_hs: RTL and testbench

- Next-generation control FSM for the multicycle RISC-V datapath.
- Adds the following over the current controller:
  - synchronous reset;
  - a memory ready/wait handshake with optional timeout;
  - I-type ALU, JALR and AUIPC classes;
  - an illegal-opcode/bus-error trap state;
  - a retired-instruction counter.
- Sits between the instruction register (opcode) / memory ready line and the datapath mux/enable inputs.

---
 rtl/riscx_ctrl_pkg.sv | 61 ++++++
 rtl/mem_wait_timer.sv | 27 ++
 rtl/multicycle_control_hs.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control_hs.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscx_ctrl_pkg.sv
// rtl/riscx_ctrl_pkg.sv - opcodes, FSM states and datapath mux encodings for the multicycle controller
package riscx_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_LOAD     = 4'd3,
      S_LOAD_WB  = 4'd4,
      S_STORE    = 4'd5,
      S_ALU_R    = 4'd6,
      S_ALU_I    = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic       ADDR_PC     = 1'b0;
   localparam logic       ADDR_ALUOUT = 1'b1;

   localparam logic [1:0] RIN_ALU     = 2'd0;
   localparam logic [1:0] RIN_MEMORY  = 2'd1;
   localparam logic [1:0] RIN_PC4     = 2'd2;
   localparam logic [1:0] RIN_IMM     = 2'd3;

   localparam logic [1:0] ALUA_PC     = 2'd0;
   localparam logic [1:0] ALUA_CURPC  = 2'd1;
   localparam logic [1:0] ALUA_REG    = 2'd2;

   localparam logic [1:0] ALUB_REG    = 2'd0;
   localparam logic [1:0] ALUB_CONST4 = 2'd1;
   localparam logic [1:0] ALUB_IMM    = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FR    = 2'd2;
   localparam logic [1:0] ALUOP_FI    = 2'd3;

   localparam logic       PC_ALU      = 1'b0;
   localparam logic       PC_ALUOUT   = 1'b1;

   // States that hold on the memory handshake and share the wait timer.
   function automatic logic is_wait_state(state_t s);
      return (s == S_FETCH) || (s == S_LOAD) || (s == S_STORE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts stalled memory cycles and flags a timeout
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic waiting,
   input  logic mem_ready,
   output logic expired
);

   logic [TO_W-1:0] count;

   // Leaving a wait state or completing the access restarts the count, so entry always sees zero.
   always_ff @(posedge clock) begin
      if (reset || !waiting || mem_ready) begin
         count <= '0;
      end else begin
         count <= count + TO_W'(1);
      end
   end

   assign expired = (MEM_TIMEOUT != 0) && waiting && !mem_ready
                    && (count == TO_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_hs.sv
// rtl/multicycle_control_hs.sv - multicycle RISC-V control FSM with memory handshake, trap and instret
module multicycle_control_hs
   import riscx_ctrl_pkg::*;
#(
   parameter int COUNT_W     = 32,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [6:0]         opcode,
   input  logic               mem_ready,
   output logic               MemoryAddressOrigin,
   output logic               WriteMemory,
   output logic               ReadMemory,
   output logic               WriteInstructionRegister,
   output logic [1:0]         RegisterInputOrigin,
   output logic               WriteRegister,
   output logic               WriteCurrentPC,
   output logic [1:0]         ALUInputAOrigin,
   output logic [1:0]         ALUInputBOrigin,
   output logic [1:0]         ALUOp,
   output logic               PCOrigin,
   output logic               WritePC,
   output logic               Branch,
   output logic               trap,
   output logic               trap_cause,
   output logic [COUNT_W-1:0] instret
);

   state_t state;
   state_t next_state;
   logic   expired;
   logic   retire;
   logic   timeout_trap;
   logic   wm_c, rm_c, wir_c, wr_c, wcp_c, wpc_c, br_c;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .TO_W       (TO_W)
   ) u_wait (
      .clock    (clock),
      .reset    (reset),
      .waiting  (is_wait_state(state)),
      .mem_ready(mem_ready),
      .expired  (expired)
   );

   always_comb begin
      next_state          = state;
      retire              = 1'b0;
      timeout_trap        = 1'b0;
      MemoryAddressOrigin = ADDR_PC;
      RegisterInputOrigin = RIN_ALU;
      ALUInputAOrigin     = ALUA_PC;
      ALUInputBOrigin     = ALUB_REG;
      ALUOp               = ALUOP_ADD;
      PCOrigin            = PC_ALU;
      wm_c                = 1'b0;
      rm_c                = 1'b0;
      wir_c               = 1'b0;
      wr_c                = 1'b0;
      wcp_c               = 1'b0;
      wpc_c               = 1'b0;
      br_c                = 1'b0;
      case (state)
         S_FETCH: begin
            rm_c            = 1'b1;
            ALUInputBOrigin = ALUB_CONST4;
            if (mem_ready) begin
               wir_c      = 1'b1;
               wcp_c      = 1'b1;
               wpc_c      = 1'b1;
               next_state = S_DECODE;
            end else if (expired) begin
               timeout_trap = 1'b1;
               next_state   = S_TRAP;
            end
         end
         S_DECODE: begin
            ALUInputAOrigin = ALUA_CURPC;
            ALUInputBOrigin = ALUB_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
               OP_R:              next_state = S_ALU_R;
               OP_I:              next_state = S_ALU_I;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_JAL:            next_state = S_JAL;
               OP_JALR:           next_state = S_JALR;
               OP_LUI:            next_state = S_LUI;
               OP_AUIPC:          next_state = S_AUIPC;
               default:           next_state = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            ALUInputAOrigin = ALUA_REG;
            ALUInputBOrigin = ALUB_IMM;
            next_state      = (opcode == OP_LOAD) ? S_LOAD : S_STORE;
         end
         S_LOAD: begin
            rm_c                = 1'b1;
            MemoryAddressOrigin = ADDR_ALUOUT;
            if (mem_ready) begin
               next_state = S_LOAD_WB;
            end else if (expired) begin
               timeout_trap = 1'b1;
               next_state   = S_TRAP;
            end
         end
         S_LOAD_WB: begin
            RegisterInputOrigin = RIN_MEMORY;
            wr_c                = 1'b1;
            retire              = 1'b1;
            next_state          = S_FETCH;
         end
         S_STORE: begin
            wm_c                = 1'b1;
            MemoryAddressOrigin = ADDR_ALUOUT;
            if (mem_ready) begin
               retire     = 1'b1;
               next_state = S_FETCH;
            end else if (expired) begin
               timeout_trap = 1'b1;
               next_state   = S_TRAP;
            end
         end
         S_ALU_R: begin
            ALUInputAOrigin = ALUA_REG;
            ALUInputBOrigin = ALUB_REG;
            ALUOp           = ALUOP_FR;
            next_state      = S_ALU_WB;
         end
         S_ALU_I: begin
            ALUInputAOrigin = ALUA_REG;
            ALUInputBOrigin = ALUB_IMM;
            ALUOp           = ALUOP_FI;
            next_state      = S_ALU_WB;
         end
         S_ALU_WB: begin
            wr_c       = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            ALUInputAOrigin = ALUA_REG;
            ALUInputBOrigin = ALUB_REG;
            ALUOp           = ALUOP_SUB;
            PCOrigin        = PC_ALUOUT;
            br_c            = 1'b1;
            retire          = 1'b1;
            next_state      = S_FETCH;
         end
         S_JAL: begin
            RegisterInputOrigin = RIN_PC4;
            wr_c                = 1'b1;
            PCOrigin            = PC_ALUOUT;
            wpc_c               = 1'b1;
            retire              = 1'b1;
            next_state          = S_FETCH;
         end
         S_JALR: begin
            ALUInputAOrigin     = ALUA_REG;
            ALUInputBOrigin     = ALUB_IMM;
            RegisterInputOrigin = RIN_PC4;
            wr_c                = 1'b1;
            wpc_c               = 1'b1;
            retire              = 1'b1;
            next_state          = S_FETCH;
         end
         S_LUI: begin
            RegisterInputOrigin = RIN_IMM;
            wr_c                = 1'b1;
            retire              = 1'b1;
            next_state          = S_FETCH;
         end
         S_AUIPC: begin
            ALUInputAOrigin = ALUA_CURPC;
            ALUInputBOrigin = ALUB_IMM;
            next_state      = S_ALU_WB;
         end
         S_TRAP: begin
            next_state = S_TRAP;
         end
         default: begin
            next_state = S_FETCH;
         end
      endcase
   end

   // Reset suppresses every write strobe so an aborted access leaves memory and registers untouched.
   assign WriteMemory              = wm_c  & ~reset;
   assign ReadMemory               = rm_c  & ~reset;
   assign WriteInstructionRegister = wir_c & ~reset;
   assign WriteRegister            = wr_c  & ~reset;
   assign WriteCurrentPC           = wcp_c & ~reset;
   assign WritePC                  = wpc_c & ~reset;
   assign Branch                   = br_c  & ~reset;
   assign trap                     = (state == S_TRAP);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_FETCH;
         trap_cause <= 1'b0;
         instret    <= '0;
      end else begin
         state <= next_state;
         if (state != S_TRAP && next_state == S_TRAP) begin
            trap_cause <= timeout_trap;
         end
         if (retire) begin
            instret <= instret + COUNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_hs.sv
// tb/tb_multicycle_control_hs.sv - directed self-checking bench for multicycle_control_hs
module tb_multicycle_control_hs;

   localparam int COUNT_W = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BAD    = 7'b1111111;

   localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, LOAD = 3, LOAD_WB = 4, STORE = 5;
   localparam int ALU_R = 6, ALU_I = 7, ALU_WB = 8, BRANCH = 9, JAL = 10, JALR = 11;
   localparam int LUI = 12, AUIPC = 13, TRAP = 14;

   // Write-strobe bit positions within the output signature.
   localparam logic [17:0] EN_MASK = 18'b011100110000000110;

   logic               clock = 1'b0;
   logic               reset;
   logic [6:0]         opcode;
   logic               mem_ready;
   logic               MemoryAddressOrigin, WriteMemory, ReadMemory, WriteInstructionRegister;
   logic [1:0]         RegisterInputOrigin;
   logic               WriteRegister, WriteCurrentPC;
   logic [1:0]         ALUInputAOrigin, ALUInputBOrigin, ALUOp;
   logic               PCOrigin, WritePC, Branch, trap, trap_cause;
   logic [COUNT_W-1:0] instret;

   int checks = 0;
   int errors = 0;

   multicycle_control_hs #(
      .COUNT_W    (COUNT_W),
      .MEM_TIMEOUT(4),
      .TO_W       (8)
   ) dut (
      .clock                   (clock),
      .reset                   (reset),
      .opcode                  (opcode),
      .mem_ready               (mem_ready),
      .MemoryAddressOrigin     (MemoryAddressOrigin),
      .WriteMemory             (WriteMemory),
      .ReadMemory              (ReadMemory),
      .WriteInstructionRegister(WriteInstructionRegister),
      .RegisterInputOrigin     (RegisterInputOrigin),
      .WriteRegister           (WriteRegister),
      .WriteCurrentPC          (WriteCurrentPC),
      .ALUInputAOrigin         (ALUInputAOrigin),
      .ALUInputBOrigin         (ALUInputBOrigin),
      .ALUOp                   (ALUOp),
      .PCOrigin                (PCOrigin),
      .WritePC                 (WritePC),
      .Branch                  (Branch),
      .trap                    (trap),
      .trap_cause              (trap_cause),
      .instret                 (instret)
   );

   always #5 clock = ~clock;

   wire [17:0] sig = {MemoryAddressOrigin, WriteMemory, ReadMemory, WriteInstructionRegister,
                      RegisterInputOrigin, WriteRegister, WriteCurrentPC, ALUInputAOrigin,
                      ALUInputBOrigin, ALUOp, PCOrigin, WritePC, Branch, trap};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] exp_sig(input int s, input logic rdy);
      logic       addr, wm, rm, wir, wr, wcp, pco, wpc, br, tr;
      logic [1:0] rin, a, b, op;
      {addr, wm, rm, wir, wr, wcp, pco, wpc, br, tr} = '0;
      {rin, a, b, op} = '0;
      case (s)
         FETCH:    begin rm = 1; b = 1; if (rdy) begin wir = 1; wcp = 1; wpc = 1; end end
         DECODE:   begin a = 1; b = 2; end
         MEM_ADDR: begin a = 2; b = 2; end
         LOAD:     begin rm = 1; addr = 1; end
         LOAD_WB:  begin rin = 1; wr = 1; end
         STORE:    begin wm = 1; addr = 1; end
         ALU_R:    begin a = 2; b = 0; op = 2; end
         ALU_I:    begin a = 2; b = 2; op = 3; end
         ALU_WB:   begin wr = 1; end
         BRANCH:   begin a = 2; b = 0; op = 1; pco = 1; br = 1; end
         JAL:      begin rin = 2; wr = 1; pco = 1; wpc = 1; end
         JALR:     begin a = 2; b = 2; rin = 2; wr = 1; wpc = 1; end
         LUI:      begin rin = 3; wr = 1; end
         AUIPC:    begin a = 1; b = 2; end
         default:  begin tr = 1; end
      endcase
      return {addr, wm, rm, wir, rin, wr, wcp, a, b, op, pco, wpc, br, tr};
   endfunction

   task automatic step(input string tag, input int s);
      logic [17:0] e;
      e = exp_sig(s, mem_ready);
      if (reset) e = e & ~EN_MASK;
      #2;
      check(tag, 64'(sig), 64'(e));
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = OPC_R;
      @(posedge clock);
      #1;
      step("reset_fetch", FETCH);
      check("reset_instret", 64'(instret), 64'd0);
      check("reset_trap", 64'({trap, trap_cause}), 64'd0);
      reset = 1'b0;

      step("r_fetch", FETCH);
      step("r_decode", DECODE);
      step("r_alu", ALU_R);
      step("r_wb", ALU_WB);
      check("r_instret", 64'(instret), 64'd1);

      opcode = OPC_LOAD;
      step("ld_fetch", FETCH);
      step("ld_decode", DECODE);
      step("ld_addr", MEM_ADDR);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("ld_wait", LOAD);
      mem_ready = 1'b1;
      step("ld_done", LOAD);
      step("ld_wb", LOAD_WB);
      check("ld_instret", 64'(instret), 64'd2);

      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) step("to_fetch", FETCH);
      step("to_trap", TRAP);
      check("to_cause", 64'({trap, trap_cause}), 64'b11);
      check("to_instret", 64'(instret), 64'd2);
      step("to_hold", TRAP);
      reset = 1'b1;
      step("to_reset", TRAP);
      reset = 1'b0;
      check("to_clr_instret", 64'(instret), 64'd0);
      check("to_clr_trap", 64'({trap, trap_cause}), 64'd0);

      opcode = OPC_R;
      for (int i = 0; i < 4; i++) step("late_fetch", FETCH);
      mem_ready = 1'b1;
      step("late_ready", FETCH);
      step("late_decode", DECODE);
      step("late_alu", ALU_R);
      step("late_wb", ALU_WB);
      check("late_instret", 64'(instret), 64'd1);

      opcode = OPC_BAD;
      step("ill_fetch", FETCH);
      step("ill_decode", DECODE);
      for (int i = 0; i < 10; i++) step("ill_trap", TRAP);
      check("ill_cause", 64'({trap, trap_cause}), 64'b10);
      check("ill_instret", 64'(instret), 64'd1);
      reset = 1'b1;
      step("ill_reset", TRAP);
      reset = 1'b0;
      check("ill_clr_instret", 64'(instret), 64'd0);

      opcode = OPC_JAL;
      step("jal_fetch", FETCH);
      step("jal_decode", DECODE);
      step("jal_exec", JAL);
      opcode = OPC_JALR;
      step("jalr_fetch", FETCH);
      step("jalr_decode", DECODE);
      step("jalr_exec", JALR);
      opcode = OPC_BRANCH;
      step("br_fetch", FETCH);
      step("br_decode", DECODE);
      step("br_exec", BRANCH);
      opcode = OPC_LUI;
      step("lui_fetch", FETCH);
      step("lui_decode", DECODE);
      step("lui_exec", LUI);
      opcode = OPC_AUIPC;
      step("auipc_fetch", FETCH);
      step("auipc_decode", DECODE);
      step("auipc_exec", AUIPC);
      step("auipc_wb", ALU_WB);
      check("seq_instret", 64'(instret), 64'd5);

      opcode = OPC_I;
      step("i_fetch", FETCH);
      step("i_decode", DECODE);
      step("i_exec", ALU_I);
      step("i_wb", ALU_WB);
      check("i_instret", 64'(instret), 64'd6);

      opcode = OPC_STORE;
      step("st_fetch", FETCH);
      step("st_decode", DECODE);
      step("st_addr", MEM_ADDR);
      mem_ready = 1'b0;
      step("st_wait", STORE);
      mem_ready = 1'b1;
      step("st_done", STORE);
      check("st_instret", 64'(instret), 64'd7);

      step("sr_fetch", FETCH);
      step("sr_decode", DECODE);
      step("sr_addr", MEM_ADDR);
      mem_ready = 1'b0;
      step("sr_wait", STORE);
      step("sr_wait", STORE);
      reset = 1'b1;
      #2;
      check("sr_wm_in_reset", 64'(WriteMemory), 64'd0);
      #0;
      step("sr_reset", STORE);
      reset = 1'b0;
      check("sr_instret", 64'(instret), 64'd0);
      step("sr_after", FETCH);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
